// File: rtl/alu_operand_regs.sv
// Operand/accumulator registers for the 8-bit ALU: A/B loading, bus drive and accumulate sequencing.
// Optional signed-overflow flag output vf is built when ALU_OVF_FLAG_EN is defined.
module alu_operand_regs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             a_out,
    input  logic             exec,
    input  logic             sub_req,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             alu_sub,
    output logic             alu_sumout,
    input  logic             alu_cf,
    input  logic             alu_zf,
    output logic             cf,
    output logic             zf,
    output logic             busy,
    output logic             done
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic             vf
`endif
);

    typedef enum logic [1:0] {StIdle, StEnable, StCapture, StDone} state_e;

    state_e state;

`ifdef ALU_OVF_FLAG_EN
    logic [WIDTH-1:0] ovf_b;
    logic [WIDTH-1:0] ovf_res;
    logic             ovf_same;

    // Local copy of the ALU result, used only to derive signed overflow.
    always_comb begin
        ovf_b    = alu_sub ? ~b_val : b_val;
        ovf_res  = a_val + ovf_b + {{(WIDTH-1){1'b0}}, alu_sub};
        ovf_same = a_val[WIDTH-1] ^ ~(b_val[WIDTH-1] ^ alu_sub);
    end
`endif

    // A only reaches the bus while idle, so it never contends with the ALU result.
    assign bus_out = (state == StIdle && a_out) ? a_val : {WIDTH{1'bz}};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= StIdle;
            a_val      <= '0;
            b_val      <= '0;
            alu_sub    <= 1'b0;
            alu_sumout <= 1'b0;
            cf         <= 1'b0;
            zf         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            vf         <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (exec) begin
                        alu_sub    <= sub_req;
                        alu_sumout <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StEnable;
                    end else begin
                        if (load_a) a_val <= bus_in;
                        if (load_b) b_val <= bus_in;
                    end
                end
                StEnable: begin
                    cf    <= alu_cf;
                    zf    <= alu_zf;
`ifdef ALU_OVF_FLAG_EN
                    vf    <= ovf_same & (a_val[WIDTH-1] ^ ovf_res[WIDTH-1]);
`endif
                    state <= StCapture;
                end
                StCapture: begin
                    a_val      <= bus_in;
                    alu_sumout <= 1'b0;
                    done       <= 1'b1;
                    state      <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
